// File: rtl/rvtrace_pkg.sv
// rvtrace_pkg: shared widths and the trace entry record for the commit trace buffer.
package rvtrace_pkg;

    localparam int SEQ_W = 16;
    localparam int TS_W  = 32;
    localparam int OVF_W = 16;

    typedef struct packed {
        logic [31:0]      pc;
        logic [4:0]       rd;
        logic [31:0]      data;
        logic [SEQ_W-1:0] seq;
        logic [TS_W-1:0]  ts;
        logic             gap;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: first-word-fall-through FIFO of trace entries; occupancy drives full/empty.
module trace_fifo
    import rvtrace_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = trace_entry_t,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  entry_t      din,
    output entry_t      dout,
    output logic [AW:0] count
);

    entry_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic pop_ok;

    assign pop_ok = pop && (count != '0);
    assign dout   = (count != '0) ? mem[rp] : '0;

    // A push during flush lands in slot 0 and becomes the sole entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= AW'(push);
            rp    <= '0;
            count <= (AW+1)'(push);
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pop_ok);
            count <= count + (AW+1)'(push) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[flush ? '0 : wp] <= din;
    end

endmodule

// File: rtl/commit_trace_buf.sv
// commit_trace_buf: tags qualifying register-write commits with seq/timestamp and buffers them;
// the core is never stalled, so overflow drops entries and flags the gap on the next stored one.
module commit_trace_buf #(
    parameter int DEPTH   = 16,
    parameter int SEQ_W   = rvtrace_pkg::SEQ_W,
    parameter int TS_W    = rvtrace_pkg::TS_W,
    parameter int DROP_X0 = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          commit_valid,
    input  logic [31:0]                   commit_pc,
    input  logic [4:0]                    commit_rd,
    input  logic [31:0]                   commit_data,
    input  logic                          flush,
    output logic                          trace_valid,
    input  logic                          trace_ready,
    output logic [31:0]                   trace_pc,
    output logic [4:0]                    trace_rd,
    output logic [31:0]                   trace_data,
    output logic [SEQ_W-1:0]              trace_seq,
    output logic [TS_W-1:0]               trace_ts,
    output logic                          trace_gap,
    output logic [AW:0]                   count,
    output logic [rvtrace_pkg::OVF_W-1:0] overflow_cnt
);

    import rvtrace_pkg::*;

    typedef struct packed {
        logic [31:0]      pc;
        logic [4:0]       rd;
        logic [31:0]      data;
        logic [SEQ_W-1:0] seq;
        logic [TS_W-1:0]  ts;
        logic             gap;
    } entry_t;

    logic [SEQ_W-1:0] seq;
    logic [TS_W-1:0]  ts;
    logic             pending_gap;
    logic             qual, pop, push, ovf, full;
    entry_t           din, head;

    assign qual        = commit_valid && !(DROP_X0 != 0 && commit_rd == '0);
    assign trace_valid = (count != '0);
    assign full        = (count == (AW+1)'(DEPTH));
    assign pop         = trace_valid && trace_ready && !flush;
    assign push        = qual && (flush || !full || pop);
    assign ovf         = qual && !push;
    assign din         = '{pc: commit_pc, rd: commit_rd, data: commit_data,
                           seq: seq, ts: ts, gap: pending_gap};

    trace_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (din),
        .dout  (head),
        .count (count)
    );

    assign trace_pc   = head.pc;
    assign trace_rd   = head.rd;
    assign trace_data = head.data;
    assign trace_seq  = head.seq;
    assign trace_ts   = head.ts;
    assign trace_gap  = head.gap;

    // Seq advances on every qualifying commit so drops show up as holes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq          <= '0;
            ts           <= '0;
            pending_gap  <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            ts <= ts + TS_W'(1);
            if (qual) seq <= seq + SEQ_W'(1);
            if (push) pending_gap <= 1'b0;
            else if (ovf) pending_gap <= 1'b1;
            if (ovf && overflow_cnt != '1) overflow_cnt <= overflow_cnt + OVF_W'(1);
        end
    end

endmodule

// File: tb/tb_commit_trace_buf.sv
// tb_commit_trace_buf: directed stimulus against a queue-based model, plus literal spot checks.
module tb_commit_trace_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = '0;
    logic [4:0]  commit_rd = '0;
    logic [31:0] commit_data = '0;
    logic        flush = 1'b0;
    logic        trace_ready = 1'b0;
    logic        trace_valid, trace_gap;
    logic [31:0] trace_pc, trace_data, trace_ts;
    logic [4:0]  trace_rd, count;
    logic [15:0] trace_seq, overflow_cnt;

    commit_trace_buf dut (
        .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_rd(commit_rd), .commit_data(commit_data), .flush(flush),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
        .trace_rd(trace_rd), .trace_data(trace_data), .trace_seq(trace_seq),
        .trace_ts(trace_ts), .trace_gap(trace_gap), .count(count), .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [15:0] seq;
        logic [31:0] ts;
        logic        gap;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_seq = '0;
    logic [31:0] m_ts = '0;
    int          m_ovf = 0;
    bit          m_pg = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_seq = '0;
        m_ts = '0;
        m_ovf = 0;
        m_pg = 1'b0;
    endtask

    // One clock edge of the buffer's rules, applied to the inputs held across that edge.
    task automatic model_update();
        ent_t e, tmp;
        bit qual;
        qual = commit_valid && commit_rd != 5'd0;
        e = '{pc: commit_pc, rd: commit_rd, data: commit_data, seq: m_seq, ts: m_ts, gap: m_pg};
        if (flush) begin
            q.delete();
            if (qual) begin q.push_back(e); m_pg = 1'b0; end
        end else begin
            if (q.size() > 0 && trace_ready) tmp = q.pop_front();
            if (qual) begin
                if (q.size() < 16) begin
                    q.push_back(e);
                    m_pg = 1'b0;
                end else begin
                    if (m_ovf < 65535) m_ovf++;
                    m_pg = 1'b1;
                end
            end
        end
        if (qual) m_seq++;
        m_ts++;
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                        input logic [31:0] d, input logic rdy, input logic fl);
        commit_valid = v;
        commit_pc = pc;
        commit_rd = rd;
        commit_data = d;
        trace_ready = rdy;
        flush = fl;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_valid", trace_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", trace_valid, q.size() != 0);
            chk("count", count, q.size());
            chk("ovf", overflow_cnt, m_ovf);
            if (q.size() != 0)
                chk("head", {trace_pc, trace_rd, trace_data, trace_seq, trace_ts, trace_gap},
                    {q[0].pc, q[0].rd, q[0].data, q[0].seq, q[0].ts, q[0].gap});
            else
                chk("empty_head", {trace_pc, trace_rd, trace_data, trace_seq, trace_ts, trace_gap}, 0);
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_valid", trace_valid, 0);
        chk("reset_count", count, 0);
        rst_n = 1'b1;
        // capture and ordering
        step(1, 32'h0, 5'd1, 32'd5, 1, 0);
        chk("t1_first", {trace_pc, trace_rd, trace_data, trace_seq, trace_ts, trace_gap},
            {32'h0, 5'd1, 32'd5, 16'd0, 32'd0, 1'b0});
        step(1, 32'h4, 5'd2, 32'd7, 1, 0);
        chk("t1_second", {trace_pc, trace_rd, trace_data, trace_seq, trace_ts, trace_gap},
            {32'h4, 5'd2, 32'd7, 16'd1, 32'd1, 1'b0});
        chk("t1_count", count, 1);
        step(0, 0, 0, 0, 1, 0);
        chk("t1_empty", trace_valid, 0);
        // x0 filtering
        step(1, 32'h8, 5'd0, 32'd9, 1, 0);
        chk("t2_x0_dropped", count, 0);
        step(1, 32'hC, 5'd3, 32'd11, 0, 0);
        chk("t2_seq", trace_seq, 2);
        step(0, 0, 0, 0, 0, 0);
        chk("t2_hold_rd", trace_rd, 3);
        step(0, 0, 0, 0, 1, 0);
        // overflow and gap
        reset_mid();
        for (int i = 0; i < 18; i++) step(1, 32'(i * 4), 5'(i % 31 + 1), 32'(i), 0, 0);
        chk("t3_count", count, 16);
        chk("t3_ovf", overflow_cnt, 2);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, 0);
        step(1, 32'h100, 5'd5, 32'd100, 0, 0);
        chk("t3_gap_seq", {trace_seq, trace_gap}, {16'd18, 1'b1});
        step(1, 32'h104, 5'd6, 32'd101, 1, 0);
        chk("t3_nogap_seq", {trace_seq, trace_gap}, {16'd19, 1'b0});
        // simultaneous push and pop at full
        for (int i = 0; i < 15; i++) step(1, 32'(32'h200 + i * 4), 5'(i + 1), 32'(i), 0, 0);
        chk("t4_full", count, 16);
        step(1, 32'h300, 5'd9, 32'd3, 1, 0);
        chk("t4_count", count, 16);
        chk("t4_ovf", overflow_cnt, 2);
        chk("t4_head_seq", trace_seq, 20);
        // flush with concurrent commit
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 32'(32'h400 + i * 4), 5'(i + 1), 32'(i), 0, 0);
        chk("t5_count5", count, 5);
        step(1, 32'h500, 5'd7, 32'hABCD, 1, 1);
        chk("t5_after_flush", {count, trace_rd, trace_seq}, {5'd1, 5'd7, 16'd41});
        // async reset mid-stream
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 32'(32'h600 + i * 4), 5'(i + 1), 32'(i), 0, 0);
        chk("t6_count9", count, 9);
        reset_mid();
        step(1, 32'h700, 5'd4, 32'd44, 0, 0);
        chk("t6_first", {trace_seq, trace_ts, trace_gap}, {16'd0, 32'd0, 1'b0});
        step(0, 0, 0, 0, 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
